btn_pulse_conditioner: RTL
==========================

# btn_pulse_conditioner

Conditions the raw push-button input ahead of the Gray-counter system. It synchronises the asynchronous button, debounces it with a stability counter and emits a single-cycle advance pulse per press. Holding the button produces auto-repeat pulses. The `pulse` output drives the counter system's step input in place of the raw `btw` wire. The debounced level is also exported for the LED/7-segment display path.

## Interface
- `DELAY`, default 1000000: consecutive stable synchronised cycles required to accept a press or a release; legal range ≥ 1.
- `REPEAT_START`, default 50000000: cycles in PRESSED before the first auto-repeat pulse; 0 disables auto-repeat.
- `REPEAT_RATE`, default 10000000: cycles between auto-repeat pulses in REPEAT; legal range ≥ 1.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion released synchronously by the top level.
- `btw`  in  1  raw mechanical button, active-high, asynchronous to `clk`, bouncy.
- `pulse`  out  1  one-cycle step strobe; registered.
- `level`  out  1  debounced button level; registered.
- `held`  out  1  high while in the REPEAT state; registered.

## Operation
- Two-flop synchroniser on `btw` produces `bs`; no other logic reads `btw`.
- One stability/interval counter, width `$clog2` of the largest parameter plus 1. Cleared on every state transition. Saturates, never wraps.
- FSM states and transitions:
  - IDLE (`level`=0): when `bs`=1, go to PRESS_WAIT with the counter at 1.
  - PRESS_WAIT: `bs`=0 returns to IDLE with no pulse (bounce rejected). When the counter reaches `DELAY` with `bs` still 1, go to PRESSED, set `level`=1 and pulse for one cycle.
  - PRESSED: `bs`=0 goes to RELEASE_WAIT. If `REPEAT_START`≠0 and `REPEAT_START` cycles elapse, go to REPEAT with a pulse. If `REPEAT_START`=0, stay here indefinitely.
  - REPEAT (`held`=1): pulse every `REPEAT_RATE` cycles. `bs`=0 goes to RELEASE_WAIT.
  - RELEASE_WAIT (`level` stays 1, `held`=0): `bs`=1 goes to PRESSED with the counter restarted and no pulse. After `DELAY` consecutive `bs`=0 cycles, go to IDLE and set `level`=0.
- A release bounce never generates a pulse. Exactly one pulse per accepted press, plus repeat pulses.
- `pulse` is never high in two consecutive cycles when `REPEAT_RATE` ≥ 2. With `REPEAT_RATE`=1, the pulse is high every cycle in REPEAT (legal).

## Timing
- Reset (`rst`=0) forces, immediately and asynchronously: state IDLE, counter 0, synchroniser flops 0, `pulse`=0, `level`=0, `held`=0.
- Reset mid-press: after release, if `btw` is still high, the full press sequence reruns, including a new pulse after the full latency.
- Press latency: `btw` high and stable from edge 0 gives `bs`=1 at edge 2. `pulse` and `level` go high at edge `DELAY`+2.
- First repeat pulse comes `REPEAT_START` cycles after the press pulse. Subsequent repeat pulses are spaced `REPEAT_RATE` cycles apart.
- Release latency: `btw` low and stable from edge r gives `level`=0 at edge r+`DELAY`+2. `held` drops at edge r+3.
- Simultaneous events: a `bs` change in the same cycle as a counter terminal count takes the `bs` branch.

## Structure
- Shared package `btn_pkg`: state enumeration (IDLE, PRESS_WAIT, PRESSED, REPEAT, RELEASE_WAIT) as a 3-bit localparam set, plus a counter-width helper function.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchroniser with an active-low async reset. It is reused by later inputs.
- `btn_pulse_conditioner` holds the FSM, the counter and the output registers.

## Test plan
All scenarios use `DELAY`=4, `REPEAT_START`=20, `REPEAT_RATE`=8 unless noted.
- Clean press, `btw` held high from edge 0 → `pulse` high only at edge 6, `level` high from edge 6.
- Bounce pattern 1,1,0,1,1,0 then stable 1 → no pulse during the bounce; exactly one pulse 6 edges after the last 0→1 transition.
- Long hold of 60 cycles → pulses at edges 6, 26, 34, 42, 50, …; `held` high from edge 26.
- Release with a glitch (low 2 cycles, high 1, then low) → no pulse, `level` stays 1 until 6 edges after the final fall.
- `REPEAT_START`=0, 100-cycle hold → exactly one pulse, `held` never asserted.
- `rst` pulsed low at edge 30 of a hold → all outputs 0 within the same cycle; after release, a new pulse 6 edges later.

Source files
------------

// File: rtl/btn_pulse_conditioner_pkg.sv
// rtl/btn_pulse_conditioner_pkg.sv - shared state set and counter sizing for the button conditioner
// Purpose: FSM state encoding (3-bit) and the stability/interval counter width helper.
// Ports: none.
package btn_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      PRESSED      = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } btn_state_t;

   // One counter serves every timed interval, so it is sized for the largest one.
   function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                    input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/btn_pulse_conditioner_if.sv
// rtl/btn_pulse_conditioner_if.sv - button input and conditioned outputs bundle
// Purpose: groups the raw button and the conditioned outputs of one button channel.
// Signals: btw   raw bouncy button (master drives)
//          pulse one-cycle step strobe (slave drives)
//          level debounced button level (slave drives)
//          held  auto-repeat active (slave drives)
interface btn_pulse_conditioner_if;
   import btn_pkg::*;

   logic btw;
   logic pulse;
   logic level;
   logic held;

   modport master (output btw, input pulse, level, held);
   modport slave  (input btw, output pulse, level, held);

endinterface

// File: rtl/btn_pulse_conditioner_sync_2ff.sv
// rtl/btn_pulse_conditioner_sync_2ff.sv - 1-bit two-flop synchroniser
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk   clock
//        rst_n asynchronous active-low reset, clears both flops
//        d_i   asynchronous input
//        q_o   synchronised output, two cycles of latency
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// rtl/btn_pulse_conditioner.sv - debounced push-button to step-pulse conditioner with auto-repeat
// Purpose: synchronises and debounces the raw button, emits one pulse per accepted
//          press and periodic pulses while the button is held.
// Ports: clk  system clock
//        rst  asynchronous active-low reset
//        bus  slave side: btw in; pulse, level, held out (all outputs registered)
module btn_pulse_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned DELAY        = 1000000,
   parameter int unsigned REPEAT_START = 50000000,
   parameter int unsigned REPEAT_RATE  = 10000000
) (
   input  logic                   clk,
   input  logic                   rst,
   btn_pulse_conditioner_if.slave bus
);

   localparam int CW = cnt_width(DELAY, REPEAT_START, REPEAT_RATE);

   logic          bs;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
   logic [31:0]   cnt_inc;
   logic          pulse_q, pulse_d;
   logic          level_q, level_d;
   logic          held_q, held_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (bus.btw),
      .q_o   (bs)
   );

   // cnt_inc counts the current cycle too, so a wait of N cycles ends when it reaches N.
   assign cnt_inc = 32'(cnt_q) + 32'd1;
   assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_sat;
      pulse_d = 1'b0;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bs) begin
               // A one-cycle debounce window is already satisfied by this sample.
               if (DELAY <= 1) begin
                  state_d = PRESSED;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CW'(1);
               end
            end
         end
         PRESS_WAIT: begin
            if (!bs) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc >= DELAY) begin
               state_d = PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
               level_d = 1'b1;
            end
         end
         PRESSED, REPEAT: begin
            // A release sample wins over any terminal count in the same cycle.
            if (!bs) begin
               if (DELAY <= 1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end else begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CW'(1);
               end
            end else if (state_q == PRESSED) begin
               if (REPEAT_START != 0 && cnt_inc >= REPEAT_START) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
               end
            end else if (cnt_inc >= REPEAT_RATE) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (bs) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc >= DELAY) begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
      held_d = (state_d == REPEAT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
         held_q  <= held_d;
      end
   end

   assign bus.pulse = pulse_q;
   assign bus.level = level_q;
   assign bus.held  = held_q;

endmodule
